// File: rtl/sa_weight_load_stage.sv
// Weight-load stage: fetches up to N_ROWS weight rows from the register file into the array, then hands the instruction on.
// Write strobe lags its grant by 1 cycle; the instruction is held on fwd_* until fwd_ready_i.
module sa_weight_load_stage #(
    parameter int N_ROWS      = 4,
    parameter int ROW_WIDTH   = 128,
    parameter int RF_AW       = 3,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   wl_ready_o,
    input  logic                   start_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [RF_AW-1:0]       wreg_i,
    input  logic [$clog2(N_ROWS+1)-1:0] nrows_i,
    output logic                   rf_req_o,
    output logic [RF_AW-1:0]       rf_reg_o,
    output logic [$clog2(N_ROWS+1)-1:0] rf_row_o,
    input  logic                   rf_gnt_i,
    input  logic [ROW_WIDTH-1:0]   rf_rdata_i,
    output logic                   w_we_o,
    output logic [$clog2(N_ROWS+1)-1:0] w_row_o,
    output logic [ROW_WIDTH-1:0]   w_data_o,
    output logic                   fwd_valid_o,
    input  logic                   fwd_ready_i,
    output logic [INSTR_WIDTH-1:0] fwd_instr_o
);

    localparam int CNT_W = $clog2(N_ROWS+1);

    typedef enum logic [1:0] {IDLE, LOAD, HANDOFF} state_t;

    state_t                 state, state_nxt, accept_target;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [RF_AW-1:0]       wreg_q;
    logic [CNT_W-1:0]       nrows_q, row_cnt, nrows_clamp;
    logic                   w_we_q;
    logic [CNT_W-1:0]       w_row_q;
    logic [ROW_WIDTH-1:0]   w_data_q;
    logic                   accept, grant, last_grant;

    // Out-of-range row counts from upstream are clamped rather than trusted.
    assign nrows_clamp   = (nrows_i > CNT_W'(N_ROWS)) ? CNT_W'(N_ROWS) : nrows_i;
    assign accept        = start_i & wl_ready_o;
    assign grant         = rf_req_o & rf_gnt_i;
    assign last_grant    = grant & (row_cnt == (nrows_q - CNT_W'(1)));
    assign accept_target = (nrows_clamp != '0) ? LOAD : HANDOFF;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = accept_target;
            LOAD:    if (last_grant) state_nxt = HANDOFF;
            HANDOFF: if (fwd_ready_i) state_nxt = accept ? accept_target : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wl_ready_o  = (state == IDLE) | ((state == HANDOFF) & fwd_ready_i);
        rf_req_o    = (state == LOAD);
        fwd_valid_o = (state == HANDOFF);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q  <= '0;
            wreg_q   <= '0;
            nrows_q  <= '0;
            row_cnt  <= '0;
            w_we_q   <= 1'b0;
            w_row_q  <= '0;
            w_data_q <= '0;
        end else begin
            if (accept) begin
                instr_q <= instr_i;
                wreg_q  <= wreg_i;
                nrows_q <= nrows_clamp;
                row_cnt <= '0;
            end else if (grant) begin
                row_cnt <= row_cnt + CNT_W'(1);
            end
            w_we_q <= grant;
            if (grant) begin
                w_row_q  <= row_cnt;
                w_data_q <= rf_rdata_i;
            end
        end
    end

    assign rf_reg_o    = wreg_q;
    assign rf_row_o    = row_cnt;
    assign w_we_o      = w_we_q;
    assign w_row_o     = w_row_q;
    assign w_data_o    = w_data_q;
    assign fwd_instr_o = instr_q;

    // Protocol misuse by upstream is flagged in simulation; hardware ignores or clamps it.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(start_i && !wl_ready_o))
                else $warning("start_i raised while stage not ready; ignored");
            assert (!(start_i && wl_ready_o && (nrows_i > CNT_W'(N_ROWS))))
                else $warning("nrows_i above N_ROWS; clamped");
        end
    end

endmodule

// File: tb/tb_sa_weight_load_stage.sv
// Bench for sa_weight_load_stage: directed scenarios with literal expectations, then randomized traffic vs a transaction model.
module tb_sa_weight_load_stage;

    localparam int N_ROWS = 4;
    localparam int RW     = 128;
    localparam int AW     = 3;
    localparam int IW     = 32;
    localparam int CW     = $clog2(N_ROWS+1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wl_ready_o;
    logic          start_i;
    logic [IW-1:0] instr_i;
    logic [AW-1:0] wreg_i;
    logic [CW-1:0] nrows_i;
    logic          rf_req_o;
    logic [AW-1:0] rf_reg_o;
    logic [CW-1:0] rf_row_o;
    logic          rf_gnt_i;
    logic [RW-1:0] rf_rdata_i;
    logic          w_we_o;
    logic [CW-1:0] w_row_o;
    logic [RW-1:0] w_data_o;
    logic          fwd_valid_o;
    logic          fwd_ready_i;
    logic [IW-1:0] fwd_instr_o;

    sa_weight_load_stage #(.N_ROWS(N_ROWS), .ROW_WIDTH(RW), .RF_AW(AW), .INSTR_WIDTH(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wl_ready_o(wl_ready_o), .start_i(start_i),
        .instr_i(instr_i), .wreg_i(wreg_i), .nrows_i(nrows_i), .rf_req_o(rf_req_o),
        .rf_reg_o(rf_reg_o), .rf_row_o(rf_row_o), .rf_gnt_i(rf_gnt_i), .rf_rdata_i(rf_rdata_i),
        .w_we_o(w_we_o), .w_row_o(w_row_o), .w_data_o(w_data_o), .fwd_valid_o(fwd_valid_o),
        .fwd_ready_i(fwd_ready_i), .fwd_instr_o(fwd_instr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: the instruction in flight and how many of its rows have been granted.
    logic          cur_valid = 1'b0;
    logic [IW-1:0] cur_instr = '0;
    logic [AW-1:0] cur_reg   = '0;
    int            cur_n     = 0;
    int            done      = 0;
    logic          exp_we    = 1'b0;
    logic [CW-1:0] exp_wrow  = '0;
    logic [RW-1:0] exp_wdata = '0;

    function automatic logic model_ready(input logic fr);
        return !cur_valid || ((done == cur_n) && fr);
    endfunction

    initial begin
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            begin
                logic e_req, e_fv, hand;
                int   done_before;
                e_req = cur_valid && (done < cur_n);
                e_fv  = cur_valid && (done == cur_n);
                check("wl_ready", RW'(wl_ready_o), RW'(model_ready(fwd_ready_i)));
                check("rf_req", RW'(rf_req_o), RW'(e_req));
                check("fwd_valid", RW'(fwd_valid_o), RW'(e_fv));
                check("w_we", RW'(w_we_o), RW'(exp_we));
                check("w_row", RW'(w_row_o), RW'(exp_wrow));
                check("w_data", w_data_o, exp_wdata);
                if (e_req) begin
                    check("rf_reg", RW'(rf_reg_o), RW'(cur_reg));
                    check("rf_row", RW'(rf_row_o), RW'(done));
                end
                if (e_fv) check("fwd_instr", RW'(fwd_instr_o), RW'(cur_instr));

                if (!rst_ni) begin
                    cur_valid = 1'b0;
                    done      = 0;
                    exp_we    = 1'b0;
                    exp_wrow  = '0;
                    exp_wdata = '0;
                end else begin
                    done_before = done;
                    hand        = model_ready(fwd_ready_i);
                    exp_we      = 1'b0;
                    if (e_req && rf_gnt_i) begin
                        exp_we    = 1'b1;
                        exp_wrow  = CW'(done);
                        exp_wdata = rf_rdata_i;
                        done++;
                    end
                    if (cur_valid && (done_before == cur_n) && fwd_ready_i) cur_valid = 1'b0;
                    if (start_i && hand) begin
                        cur_valid = 1'b1;
                        cur_instr = instr_i;
                        cur_reg   = wreg_i;
                        cur_n     = (int'(nrows_i) > N_ROWS) ? N_ROWS : int'(nrows_i);
                        done      = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; instr_i = '0; wreg_i = '0; nrows_i = '0;
        rf_gnt_i = 1'b0; rf_rdata_i = '0; fwd_ready_i = 1'b0;
        step(); step();
        check("rst_wl_ready", RW'(wl_ready_o), RW'(1));
        check("rst_w_data", w_data_o, '0);
        check("rst_w_row", RW'(w_row_o), RW'(0));
        check("rst_fwd_instr", RW'(fwd_instr_o), RW'(0));
        rst_ni = 1'b1;
        step();

        // Four rows with grant tied high, plus an illegal start mid-load.
        start_i = 1'b1; instr_i = 32'hA0A0_0001; wreg_i = 3'd5; nrows_i = 3'd4; rf_gnt_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rf_rdata_i = RW'(32'h1000 + k);
            check("lit_rf_req", RW'(rf_req_o), RW'(1));
            check("lit_rf_row", RW'(rf_row_o), RW'(k));
            if (k > 0) check("lit_w_row", RW'(w_row_o), RW'(k - 1));
            if (k == 1) begin start_i = 1'b1; instr_i = 32'hFFFF_FFFF; end
            else begin start_i = 1'b0; end
            step();
        end
        check("lit_fwd_valid", RW'(fwd_valid_o), RW'(1));
        check("lit_last_we", RW'(w_we_o), RW'(1));
        check("lit_last_row", RW'(w_row_o), RW'(3));
        check("lit_last_data", w_data_o, RW'(32'h1003));
        check("lit_instr_kept", RW'(fwd_instr_o), RW'(32'hA0A0_0001));
        fwd_ready_i = 1'b1;
        step();
        check("lit_idle", RW'(fwd_valid_o), RW'(0));

        // Zero rows goes straight to handoff.
        start_i = 1'b1; instr_i = 32'hB0B0_0002; nrows_i = 3'd0; fwd_ready_i = 1'b0;
        step();
        start_i = 1'b0;
        check("lit_n0_fv", RW'(fwd_valid_o), RW'(1));
        check("lit_n0_req", RW'(rf_req_o), RW'(0));
        check("lit_n0_we", RW'(w_we_o), RW'(0));

        // Stalled handoff, then back-to-back accept.
        for (int k = 0; k < 5; k++) begin
            check("lit_stall_fv", RW'(fwd_valid_o), RW'(1));
            check("lit_stall_rdy", RW'(wl_ready_o), RW'(0));
            step();
        end
        fwd_ready_i = 1'b1; start_i = 1'b1; instr_i = 32'hC0C0_0003; wreg_i = 3'd2; nrows_i = 3'd2;
        step();
        start_i = 1'b0; fwd_ready_i = 1'b0;
        check("lit_b2b_req", RW'(rf_req_o), RW'(1));
        check("lit_b2b_row", RW'(rf_row_o), RW'(0));
        step(); step();
        fwd_ready_i = 1'b1;
        step();

        // Reset while fetching row 2 of 4.
        start_i = 1'b1; nrows_i = 3'd4; fwd_ready_i = 1'b0;
        step();
        start_i = 1'b0;
        step(); step();
        check("lit_rst_row2", RW'(rf_row_o), RW'(2));
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("lit_rst_rdy", RW'(wl_ready_o), RW'(1));
        check("lit_rst_we", RW'(w_we_o), RW'(0));
        check("lit_rst_fv", RW'(fwd_valid_o), RW'(0));
        step();
        check("lit_rst_we2", RW'(w_we_o), RW'(0));

        // Randomized traffic; starts are only issued when the model says the stage is ready.
        for (int c = 0; c < 3000; c++) begin
            rst_ni      = ($urandom_range(0, 299) != 0);
            rf_gnt_i    = ($urandom_range(0, 3) != 0);
            rf_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
            fwd_ready_i = ($urandom_range(0, 2) != 0);
            instr_i     = $urandom;
            wreg_i      = AW'($urandom_range(0, 7));
            nrows_i     = CW'($urandom_range(0, N_ROWS));
            start_i     = model_ready(fwd_ready_i) && ($urandom_range(0, 1) == 1);
            step();
        end
        start_i = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_weight_load_stage.md
SA_WEIGHT_LOAD_STAGE -- requirements
Module: sa_weight_load_stage

Interface
REQ-001 SHALL have parameter N_ROWS, default 4, systolic array rows (maximum weight rows per instruction).
REQ-002 SHALL have parameter ROW_WIDTH, default 128, bits per weight row.
REQ-003 SHALL have parameter RF_AW, default 3, register-file index width.
REQ-004 SHALL have parameter INSTR_WIDTH, default 32, width of the opaque instruction payload.
REQ-005 SHALL have localparam CNT_W = $clog2(N_ROWS+1).
REQ-006 SHALL have port clk_i, input, 1, sole clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset; one clock, reset synchronous and active-low.
REQ-008 SHALL have port wl_ready_o, output, 1, stage can accept an instruction this cycle.
REQ-009 SHALL have port start_i, input, 1, upstream issues an instruction; legal only when wl_ready_o=1.
REQ-010 SHALL have port instr_i, input, INSTR_WIDTH, instruction payload, carried through unmodified.
REQ-011 SHALL have port wreg_i, input, RF_AW, register holding the weights.
REQ-012 SHALL have port nrows_i, input, CNT_W, rows to load (0..N_ROWS).
REQ-013 SHALL have port rf_req_o, input/output direction output, 1, register-file read request.
REQ-014 SHALL have port rf_reg_o, output, RF_AW, register index.
REQ-015 SHALL have port rf_row_o, output, CNT_W, row index.
REQ-016 SHALL have port rf_gnt_i, input, 1, read granted; rf_rdata_i valid in the same cycle.
REQ-017 SHALL have port rf_rdata_i, input, ROW_WIDTH, row data.
REQ-018 SHALL have port w_we_o, output, 1, weight row write strobe to the array.
REQ-019 SHALL have port w_row_o, output, CNT_W, array row written.
REQ-020 SHALL have port w_data_o, output, ROW_WIDTH, weight data.
REQ-021 SHALL have port fwd_valid_o, output, 1, instruction offered to the compute stage.
REQ-022 SHALL have port fwd_ready_i, input, 1, compute stage accepts.
REQ-023 SHALL have port fwd_instr_o, output, INSTR_WIDTH, latched payload.

Function
REQ-024 SHALL implement an FSM with states IDLE, LOAD and HANDOFF.
REQ-025 SHALL drive wl_ready_o = (state==IDLE) | (state==HANDOFF & fwd_ready_i).
REQ-026 SHALL, on start_i & wl_ready_o, latch instr_i, wreg_i and nrows_i, and clear the row counter to 0.
REQ-027 SHALL, on that accept, enter LOAD if nrows_i != 0, else HANDOFF directly.
REQ-028 SHALL ignore start_i when wl_ready_o=0, with no state change (simulation assertion flags it).
REQ-029 SHALL, in LOAD, assert rf_req_o=1 with rf_reg_o = latched wreg and rf_row_o = row counter.
REQ-030 SHALL hold rf_req_o and the address stable until rf_gnt_i.
REQ-031 SHALL keep rf_req_o=0 in IDLE and HANDOFF.
REQ-032 SHALL, on rf_req_o & rf_gnt_i, register rf_rdata_i and the row index, then pulse w_we_o for exactly one cycle on the next cycle (1-cycle latency).
REQ-033 SHALL, on rf_req_o & rf_gnt_i, increment the row counter.
REQ-034 SHALL hold w_data_o and w_row_o at their last values when w_we_o=0.
REQ-035 SHALL, when the grant is for row (latched nrows-1), go to HANDOFF on the next cycle.
REQ-036 SHALL issue at most one request per cycle; with rf_gnt_i tied high, N rows take N LOAD cycles.
REQ-037 SHALL, in HANDOFF, assert fwd_valid_o=1 with fwd_instr_o = latched instr, stable until fwd_ready_i.
REQ-038 SHALL NOT drop fwd_valid_o without a handshake.
REQ-039 SHALL, on fwd_valid_o & fwd_ready_i without start_i, go to IDLE.
REQ-040 SHALL, on fwd_valid_o & fwd_ready_i with start_i, re-latch per REQ-026 and go to LOAD/HANDOFF (back-to-back, no idle bubble).
REQ-041 SHALL guarantee the last w_we_o of an instruction occurs no later than the first cycle fwd_valid_o=1 for that instruction.
REQ-042 SHALL always have nrows_i <= N_ROWS from upstream; values above N_ROWS are an assertion failure, and the design clamps them to N_ROWS.

Reset
REQ-043 SHALL, with rst_ni=0 at a clock edge, go to IDLE, clear the row counter, and drive rf_req_o=0, w_we_o=0, fwd_valid_o=0.
REQ-044 SHALL, under reset, drive w_data_o=0, w_row_o=0, fwd_instr_o=0, and wl_ready_o=1 from the first cycle after reset.
REQ-045 SHALL, on reset mid-LOAD or mid-HANDOFF, abandon the in-flight instruction and produce no further w_we_o or fwd_valid_o for it.

Verification
REQ-046 SHALL cover: nrows=4, rf_gnt_i=1 -> rf_row_o 0,1,2,3 on 4 consecutive cycles; w_we_o rows 0..3 one cycle later; fwd_valid_o the cycle after the last grant.
REQ-047 SHALL cover: nrows=0 -> no rf_req_o and no w_we_o; fwd_valid_o the cycle after start_i.
REQ-048 SHALL cover: nrows=2, rf_gnt_i low 3 cycles on row 1 -> address held stable; exactly 2 w_we_o pulses, row 1 data = value at grant.
REQ-049 SHALL cover: fwd_ready_i=0 for 5 cycles -> fwd_valid_o and fwd_instr_o stable, wl_ready_o=0; on ready with start_i the next instruction enters LOAD the following cycle.
REQ-050 SHALL cover: rst_ni=0 during LOAD row 2 of 4 -> next cycle IDLE, wl_ready_o=1, no further w_we_o or fwd_valid_o.
REQ-051 SHALL cover: start_i asserted while in LOAD -> ignored, latched payload unchanged, assertion fires.
